// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared state type and default parameters for the register write arbiter
package reg_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  localparam int N_REQ_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_HOLD_DEF = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker returning the first request at or after ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PW-1:0]    pick_idx,
  output logic             any
);
  logic [PW-1:0] j;
  assign any = |req;
  // scan from the farthest slot back toward ptr so the nearest requester wins
  always_comb begin
    pick = '0;
    pick_idx = '0;
    j = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N_REQ);
      if (req[j]) begin
        pick = '0;
        pick[j] = 1'b1;
        pick_idx = j;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin, burst-bounded write arbiter in front of an enable-loaded register
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       reg_d,
  output logic                    reg_en,
  output logic                    busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_HOLD + 1);
  arb_state_t state, state_n;
  logic [PW-1:0] ptr, owner, pick_idx;
  logic [CW-1:0] cnt;
  logic [N_REQ-1:0] pick;
  logic any, acc, rel;
  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr),
    .pick(pick),
    .pick_idx(pick_idx),
    .any(any)
  );
  assign ack = gnt & req;
  assign busy = state == GRANT;
  assign acc = busy && req[owner];
  assign rel = busy && (!req[owner] || last[owner] || cnt == CW'(MAX_HOLD - 1));
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state: grant on any request, return to idle on any release condition
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = any ? GRANT : IDLE;
    else state_n = rel ? IDLE : GRANT;
  end
  // grant bookkeeping, burst counter and registered write presented to the register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      gnt <= '0;
      reg_en <= 1'b0;
      reg_d <= '0;
    end else begin
      reg_en <= acc;
      if (acc) reg_d <= wdata[owner*DATA_W +: DATA_W];
      if (state == IDLE && any) begin
        owner <= pick_idx;
        gnt <= pick;
        cnt <= '0;
      end else if (acc) cnt <= cnt + 1'b1;
      if (rel) begin
        gnt <= '0;
        ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios checked every cycle against a behavioural arbiter model
module tb_reg_write_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] last = '0;
  logic [N-1:0] gnt, ack;
  logic [DW-1:0] reg_d;
  logic reg_en, busy;
  int checks = 0;
  int errors = 0;
  logic [8:0] q [N][$];
  logic [N-1:0] m_gnt = '0;
  logic [N-1:0] m_ackd = '0;
  logic [DW-1:0] m_reg_d = '0;
  logic m_reg_en = 1'b0;
  logic m_busy = 1'b0;
  int m_owner = 0;
  int m_cnt = 0;
  int m_ptr = 0;
  logic [DW-1:0] qlog[$];
  int gnt_log[$];
  int burst_log[$];
  int ack_cnt [N];
  logic [N-1:0] prev_gnt = '0;
  int cur = 0;

  reg_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .last(last),
    .gnt(gnt), .ack(ack), .reg_d(reg_d), .reg_en(reg_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: who owns the register, how many writes it made, and what the register sees next
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_gnt = '0; m_ackd = '0; m_reg_d = '0; m_reg_en = 1'b0;
      m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else begin
      m_ackd = m_gnt & req;
      m_reg_en = 1'b0;
      if (!m_busy) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        if (req != 0) begin
          m_busy = 1'b1;
          m_cnt = 0;
          m_gnt = '0;
          m_gnt[m_owner] = 1'b1;
        end
      end else begin
        bit done;
        done = !req[m_owner];
        if (req[m_owner]) begin
          m_cnt = m_cnt + 1;
          m_reg_d = wdata[m_owner*DW +: DW];
          m_reg_en = 1'b1;
          done = last[m_owner] || m_cnt == MH;
        end
        if (done) begin
          m_busy = 1'b0;
          m_gnt = '0;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end
  end

  // per-cycle comparison plus logs of grants, burst lengths and register captures
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("ack", 32'(ack), 32'(m_gnt & req));
      chk("reg_d", 32'(reg_d), 32'(m_reg_d));
      chk("reg_en", 32'(reg_en), 32'(m_reg_en));
      chk("busy", 32'(busy), 32'(m_busy));
    end
    for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
    if (ack != 0) cur++;
    if (gnt != 0 && gnt != prev_gnt)
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
    if (prev_gnt != 0 && gnt == 0) begin
      burst_log.push_back(cur);
      cur = 0;
    end
    prev_gnt = gnt;
  end

  always @(posedge clk) if (!reset && reg_en) qlog.push_back(reg_d);

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      req[i] = q[i].size() != 0;
      wdata[i*DW +: DW] = q[i].size() != 0 ? q[i][0][7:0] : 8'h00;
      last[i] = q[i].size() != 0 ? q[i][0][8] : 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (m_ackd[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
  endtask

  task automatic clear_logs();
    qlog.delete(); gnt_log.delete(); burst_log.delete();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  task automatic drain(input string name);
    int n;
    bit pend;
    n = 0;
    do begin
      cycle();
      n++;
      pend = m_busy || m_reg_en;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) pend = 1'b1;
    end while (pend && n < 300);
    cycle();
    cycle();
    checks++;
    if (pend) begin
      errors++;
      $display("FAIL %s_timeout: still pending after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic reset_zero(input string name);
    chk({name, "_gnt"}, 32'(gnt), 0);
    chk({name, "_ack"}, 32'(ack), 0);
    chk({name, "_reg_en"}, 32'(reg_en), 0);
    chk({name, "_reg_d"}, 32'(reg_d), 0);
    chk({name, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_zero("rst0");
    reset = 1'b0;
    clear_logs();
    // fairness: everyone requests continuously without last
    for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) q[i].push_back({1'b0, 8'(i*16 + j)});
    refresh();
    drain("fair");
    chk("fair_n", gnt_log.size(), 8);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], i % N);
    foreach (burst_log[i]) chk("fair_burst", burst_log[i], 4);
    for (int i = 0; i < N; i++) chk("fair_acks", ack_cnt[i], 8);
    chk("fair_ptr", m_ptr, 0);
    // single requester burst with last on the third write
    clear_logs();
    q[2].push_back({1'b0, 8'hAA});
    q[2].push_back({1'b0, 8'hCC});
    q[2].push_back({1'b1, 8'hFF});
    refresh();
    drain("burst");
    chk("burst_q_n", qlog.size(), 3);
    if (qlog.size() == 3) begin
      chk("burst_q0", qlog[0], 8'hAA);
      chk("burst_q1", qlog[1], 8'hCC);
      chk("burst_q2", qlog[2], 8'hFF);
    end
    chk("burst_acks", ack_cnt[2], 3);
    chk("burst_ptr", m_ptr, 3);
    // wrap-around from ptr 3 to requester 1
    clear_logs();
    q[1].push_back({1'b1, 8'h11});
    refresh();
    drain("wrap");
    chk("wrap_gnt_n", gnt_log.size(), 1);
    if (gnt_log.size() != 0) chk("wrap_gnt", gnt_log[0], 1);
    chk("wrap_ptr", m_ptr, 2);
    // owner 0 withdraws after one write while requester 1 waits
    clear_logs();
    q[0].push_back({1'b0, 8'h5A});
    q[1].push_back({1'b0, 8'h21});
    q[1].push_back({1'b1, 8'h22});
    refresh();
    drain("wd");
    chk("wd_gnt_n", gnt_log.size(), 2);
    chk("wd_burst_n", burst_log.size(), 2);
    if (gnt_log.size() == 2 && burst_log.size() == 2) begin
      chk("wd_gnt0", gnt_log[0], 0);
      chk("wd_gnt1", gnt_log[1], 1);
      chk("wd_burst0", burst_log[0], 1);
      chk("wd_burst1", burst_log[1], 2);
    end
    // last coinciding with the hold limit releases once
    clear_logs();
    for (int j = 0; j < 5; j++) q[3].push_back({j >= 3, 8'(8'h30 + j)});
    q[0].push_back({1'b1, 8'h0F});
    refresh();
    drain("lh");
    chk("lh_gnt_n", gnt_log.size(), 3);
    chk("lh_burst_n", burst_log.size(), 3);
    if (gnt_log.size() == 3 && burst_log.size() == 3) begin
      chk("lh_gnt0", gnt_log[0], 3);
      chk("lh_gnt1", gnt_log[1], 0);
      chk("lh_gnt2", gnt_log[2], 3);
      chk("lh_burst0", burst_log[0], 4);
      chk("lh_burst1", burst_log[1], 1);
      chk("lh_burst2", burst_log[2], 1);
    end
    chk("lh_acks3", ack_cnt[3], 5);
    chk("lh_ptr", m_ptr, 0);
    // reset in the middle of requester 1's burst, then arbitration restarts at 0
    clear_logs();
    for (int i = 1; i < N; i++) for (int j = 0; j < 6; j++) q[i].push_back({1'b0, 8'(8'h80 + i*16 + j)});
    refresh();
    repeat (3) cycle();
    chk("mid_busy", 32'(busy), 1);
    chk("mid_reg_en", 32'(reg_en), 1);
    reset = 1'b1;
    #1;
    reset_zero("rst1");
    for (int j = 0; j < 2; j++) q[0].push_back({1'b0, 8'h01 + 8'(j)});
    refresh();
    repeat (2) cycle();
    reset = 1'b0;
    gnt_log.delete();
    drain("rst");
    chk("rst_first_gnt_n", 32'(gnt_log.size() != 0), 1);
    if (gnt_log.size() != 0) chk("rst_first_gnt", gnt_log[0], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
